// File: rtl/bubble_sort.sv
// Purpose: buffers one burst of up to MAX_N bytes, bubble-sorts it in place, then streams it out largest first.
// Latency: one compare-and-swap per cycle; out_valid rises (count-1)*(count-1)+3 cycles after the burst ends in the worst case.
// Backpressure: none; input arriving while a job is sorting or draining is dropped, and output cannot be stalled.
module bubble_sort #(
    parameter int MAX_N = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data
);

    localparam int CW = $clog2(MAX_N + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_N);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] j;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] out_idx;
    logic          swapped;
    logic          sort_done;

    logic [7:0]    mem [0:MAX_N-1];

    logic [CW-1:0] last_j;
    logic [CW-1:0] j_nxt;
    logic [7:0]    cur_a;
    logic [7:0]    cur_b;
    logic          do_cmp;
    logic          do_swap;
    logic          load_wr;
    logic [CW-1:0] load_idx;

    assign last_j   = count - CW'(2);
    assign j_nxt    = j + CW'(1);
    assign cur_a    = mem[j];
    assign cur_b    = mem[j_nxt];
    assign do_cmp   = (state == SORT) && !sort_done;
    // Strict less-than keeps equal samples where they are.
    assign do_swap  = do_cmp && (cur_a < cur_b);
    // IDLE waits for out_valid to drop so a sample overlapping the last output beat is not taken.
    assign load_wr  = ((state == IDLE) && in_valid && !out_valid) ||
                      ((state == LOAD) && in_valid && (count < MAX_C));
    assign load_idx = (state == IDLE) ? '0 : count;

    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[load_idx] <= in_data;
        end
        if (do_swap) begin
            mem[j]     <= cur_b;
            mem[j_nxt] <= cur_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            j         <= '0;
            pass_cnt  <= '0;
            out_idx   <= '0;
            swapped   <= 1'b0;
            sort_done <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            case (state)
                IDLE: begin
                    if (in_valid && !out_valid) begin
                        count <= CW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (count < MAX_C) begin
                            count <= count + CW'(1);
                        end
                    end else begin
                        state     <= SORT;
                        j         <= '0;
                        pass_cnt  <= '0;
                        swapped   <= 1'b0;
                        sort_done <= (count <= CW'(1));
                    end
                end
                SORT: begin
                    // sort_done spends one settling cycle before the drain starts.
                    if (sort_done) begin
                        state   <= OUT;
                        out_idx <= '0;
                    end else if (j == last_j) begin
                        if (!(swapped || do_swap) || (pass_cnt == last_j)) begin
                            sort_done <= 1'b1;
                        end else begin
                            j        <= '0;
                            pass_cnt <= pass_cnt + CW'(1);
                            swapped  <= 1'b0;
                        end
                    end else begin
                        j       <= j_nxt;
                        swapped <= swapped || do_swap;
                    end
                end
                OUT: begin
                    out_valid <= 1'b1;
                    out_data  <= mem[out_idx];
                    if (out_idx == count - CW'(1)) begin
                        state <= IDLE;
                    end else begin
                        out_idx <= out_idx + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort.sv
// Directed and random jobs against a queue-sorting reference model of bubble_sort.
module tb_bubble_sort;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bubble_sort #(.MAX_N(255)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sends one burst, optionally pokes in_valid while sorting, then collects and scores the output.
    task automatic run_job(input string tag, input logic [7:0] d[$], input int exp_lat, input bit glitch);
        logic [7:0] model[$];
        logic [7:0] got[$];
        int n;
        int t0;
        int lat;
        int budget;
        bit seen;
        model = d;
        while (model.size() > 255) model.pop_back();
        model.rsort();
        n = model.size();
        @(posedge clk); #1;
        foreach (d[i]) begin
            in_valid = 1'b1;
            in_data  = d[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
        t0 = cyc;
        if (glitch) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 8'hFF;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 8'd0;
        end
        budget = (n - 1) * (n - 1) + 10;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_out_seen"}, 32'(seen), 32'd1);
        lat = cyc - t0;
        if (seen) begin
            if (exp_lat >= 0)
                check({tag, "_latency"}, lat, exp_lat);
            else
                check({tag, "_latency_bound"}, 32'(lat <= (n - 1) * (n - 1) + 3), 32'd1);
            while (out_valid === 1'b1 && got.size() < 300) begin
                got.push_back(out_data);
                @(negedge clk);
            end
            check({tag, "_out_count"}, got.size(), n);
            foreach (model[i]) begin
                if (i < got.size())
                    check($sformatf("%s_dat%0d", tag, i), got[i], model[i]);
            end
            check({tag, "_idle_data"}, out_data, 32'd0);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int dummy;
        int stale;

        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_out_valid", out_valid, 32'd0);

        q = {8'd3, 8'd200};
        run_job("n2", q, -1, 1'b0);

        q = {8'd42};
        run_job("n1", q, 3, 1'b0);

        q = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        run_job("desc5", q, 7, 1'b0);

        q = {};
        repeat (6) q.push_back(8'd7);
        run_job("eq7_glitch", q, -1, 1'b1);

        q = {8'd0, 8'd1, 8'd254, 8'd255};
        run_job("asc4", q, -1, 1'b0);

        dummy = $urandom(30);
        q = {};
        repeat (255) q.push_back(8'($urandom));
        run_job("rand255", q, -1, 1'b0);

        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        for (int i = 0; i < 4; i++) q.push_back(8'(i));
        run_job("burst260", q, -1, 1'b0);

        // Abort a long sort with reset, then make sure nothing from it leaks out.
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midsort_reset_valid", out_valid, 32'd0);
        check("midsort_reset_data", out_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        check("no_stale_output", stale, 32'd0);

        q = {8'd1, 8'd9, 8'd5};
        run_job("post_reset3", q, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
